ram_arbiter: RTL

Two-core RAM arbiter and sequencer that sits between the per-core instruction and data caches and the single-ported RAM model. It grants one of four requesters per transaction: d0, d1, i0 and i1. Data requests take priority over instruction requests, and each class is round-robin within itself. A starvation limit guarantees instruction progress, and a watchdog aborts RAM transactions that stall or error.

---
 rtl/ram_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-core RAM arbiter: grants one of d0/d1/i0/i1 per transaction, data over instruction,
// round-robin within each class, with starvation limit and stall/error watchdog.
module ram_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] iaddr,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       iwait,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] iload,
  output logic [1:0][31:0] dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic             fault,
  output logic [1:0]       fault_id
);
  localparam int              SCW       = (STARVE_LIM < 8) ? 3 : $clog2(STARVE_LIM + 1);
  localparam logic [SCW-1:0]  SCNT_MAX  = SCW'(STARVE_LIM);
  localparam logic [7:0]      TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0]      RS_ACCESS = 2'd2;
  localparam logic [1:0]      RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_reg, state_next;
  logic           dptr_reg, dptr_next;
  logic           iptr_reg, iptr_next;
  logic [SCW-1:0] scnt_reg, scnt_next;
  logic [7:0]     tcnt_reg, tcnt_next;
  logic           instr_reg, instr_next;
  logic           core_reg, core_next;
  logic           write_reg, write_next;
  logic [31:0]    addr_reg, addr_next;
  logic [31:0]    store_reg, store_next;

  logic [1:0] dreq, ireq;
  logic       any_d, any_i, pick_instr;
  logic       d_core, i_core, gnt_core;
  logic       xfer, done, abort;

  assign dreq  = dREN | dWEN;
  assign ireq  = iREN;
  assign any_d = |dreq;
  assign any_i = |ireq;

  // Instruction class wins when starved or when no data request is present.
  assign pick_instr = (any_i && (scnt_reg == SCNT_MAX)) || !any_d;
  assign d_core     = dreq[dptr_reg] ? dptr_reg : ~dptr_reg;
  assign i_core     = ireq[iptr_reg] ? iptr_reg : ~iptr_reg;
  assign gnt_core   = pick_instr ? i_core : d_core;

  assign xfer  = (state_reg == XFER);
  assign done  = xfer && (ramstate == RS_ACCESS);
  assign abort = xfer && !done && ((ramstate == RS_ERROR) || (tcnt_reg == TCNT_LAST));

  always_comb begin
    state_next = state_reg;
    dptr_next  = dptr_reg;
    iptr_next  = iptr_reg;
    scnt_next  = scnt_reg;
    tcnt_next  = tcnt_reg;
    instr_next = instr_reg;
    core_next  = core_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    case (state_reg)
      IDLE: begin
        if (any_d || any_i) begin
          state_next = XFER;
          instr_next = pick_instr;
          core_next  = gnt_core;
          tcnt_next  = '0;
          if (pick_instr) begin
            iptr_next  = ~gnt_core;
            scnt_next  = '0;
            write_next = 1'b0;
            addr_next  = iaddr[gnt_core];
            store_next = '0;
          end else begin
            dptr_next  = ~gnt_core;
            write_next = dWEN[gnt_core];
            addr_next  = daddr[gnt_core];
            store_next = dWEN[gnt_core] ? dstore[gnt_core] : '0;
            // Count data grants only while an instruction request is left waiting.
            if (!any_i)
              scnt_next = '0;
            else if (scnt_reg != SCNT_MAX)
              scnt_next = scnt_reg + 1'b1;
          end
        end
      end
      XFER: begin
        if (!done)
          tcnt_next = tcnt_reg + 1'b1;
        if (done || abort)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      dptr_reg  <= 1'b0;
      iptr_reg  <= 1'b0;
      scnt_reg  <= '0;
      tcnt_reg  <= '0;
      instr_reg <= 1'b0;
      core_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      store_reg <= '0;
    end else begin
      state_reg <= state_next;
      dptr_reg  <= dptr_next;
      iptr_reg  <= iptr_next;
      scnt_reg  <= scnt_next;
      tcnt_reg  <= tcnt_next;
      instr_reg <= instr_next;
      core_reg  <= core_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
    end
  end

  assign ramREN   = xfer && !write_reg;
  assign ramWEN   = xfer && write_reg;
  assign ramaddr  = xfer ? addr_reg : '0;
  assign ramstore = xfer ? store_reg : '0;
  assign fault    = abort;
  assign fault_id = abort ? {instr_reg, core_reg} : 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_core
      logic sel_d, sel_i;
      assign sel_d     = xfer && !instr_reg && (core_reg == 1'(gi));
      assign sel_i     = xfer && instr_reg && (core_reg == 1'(gi));
      assign dload[gi] = sel_d ? ramload : '0;
      assign iload[gi] = sel_i ? ramload : '0;
      assign dwait[gi] = !(sel_d && done);
      assign iwait[gi] = !(sel_i && done);
    end
  endgenerate

endmodule
